example_mul_mac_pipe: RTL and testbench

EXAMPLE_MUL_MAC_PIPE -- requirements
Module: example_mul_mac_pipe

---
 rtl/example_mul_mac_pipe_pkg.sv | 22 ++
 rtl/example_mul_mac_pipe_if.sv | 34 +++
 rtl/example_mul_mac_pipe_mult.sv | 67 ++++++
 rtl/example_mul_mac_pipe.sv | 109 ++++++++++
 tb/tb_example_mul_mac_pipe.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/example_mul_mac_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : example_mac_pkg
// Description : Mode encodings and saturation bounds shared by the MAC pipe.
// Revision    : 1.0
// ============================================================================
package example_mac_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    // Two's-complement bounds of a w-bit signed value, w <= 64.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/example_mul_mac_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface   : example_mul_mac_pipe_if
// Description : Input beat / output result handshakes of the MAC pipe.
// Revision    : 1.0
// ============================================================================
interface example_mul_mac_pipe_if #(
    parameter int A_W   = 14,
    parameter int B_W   = 8,
    parameter int ACC_W = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [A_W-1:0]   in_a;
    logic        [B_W-1:0]   in_b;
    logic                    in_mode;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_p;
    logic                    out_ovf;
    logic                    busy;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_p, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_p, out_ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/example_mul_mac_pipe_mult.sv
`default_nettype none
// ============================================================================
// Module      : example_mul_mac_pipe_mult
// Description : Signed x unsigned multiplier followed by DEPTH register
//               stages carrying the beat's valid/mode/last sideband.
// Revision    : 1.0
// ============================================================================
module example_mul_mac_pipe_mult
    import example_mac_pkg::*;
#(
    parameter int A_W   = 14,
    parameter int B_W   = 8,
    parameter int DEPTH = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   i_en,
    input  wire logic                   i_valid,
    input  wire logic                   i_mode,
    input  wire logic                   i_last,
    input  wire logic signed [A_W-1:0]  i_a,
    input  wire logic        [B_W-1:0]  i_b,
    output logic                        o_valid,
    output logic                        o_mode,
    output logic                        o_last,
    output logic signed [A_W+B_W:0]     o_prod
);
    localparam int c_pw = A_W + B_W + 1;

    logic signed [c_pw-1:0] w_prod;
    logic signed [c_pw-1:0] r_prod [DEPTH];
    logic        [DEPTH-1:0] r_valid;
    logic        [DEPTH-1:0] r_mode;
    logic        [DEPTH-1:0] r_last;

    // Both operands widened to the full product width so the multiply is exact.
    assign w_prod = c_pw'(i_a) * c_pw'($signed({1'b0, i_b}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_prod[i] <= '0;
            end
            r_valid <= '0;
            r_mode  <= '0;
            r_last  <= '0;
        end else if (i_en) begin
            r_prod[0]  <= w_prod;
            r_valid[0] <= i_valid;
            r_mode[0]  <= i_mode;
            r_last[0]  <= i_last;
            for (int i = 1; i < DEPTH; i++) begin
                r_prod[i]  <= r_prod[i-1];
                r_valid[i] <= r_valid[i-1];
                r_mode[i]  <= r_mode[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    assign o_prod  = r_prod[DEPTH-1];
    assign o_valid = r_valid[DEPTH-1];
    assign o_mode  = r_mode[DEPTH-1];
    assign o_last  = r_last[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/example_mul_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : example_mul_mac_pipe
// Description : Pipelined multiply / saturating multiply-accumulate unit with
//               a single global stall derived from output backpressure.
// Revision    : 1.0
// ============================================================================
module example_mul_mac_pipe
    import example_mac_pkg::*;
#(
    parameter int A_W       = 14,
    parameter int B_W       = 8,
    parameter int ACC_W     = 32,
    parameter int NUM_STAGE = 3
) (
    input  wire logic             ap_clk,
    input  wire logic             ap_rst_n,
    example_mul_mac_pipe_if.slave bus
);
    localparam int                      c_pw      = A_W + B_W + 1;
    localparam logic signed [ACC_W-1:0] c_acc_max = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] c_acc_min = ACC_W'(sat_min(ACC_W));

    logic                    w_en;
    logic                    w_s_valid;
    logic                    w_s_mode;
    logic                    w_s_last;
    logic signed [c_pw-1:0]  w_s_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic        [ACC_W:0]   w_sum_wide;
    logic                    w_add_sat;
    logic signed [ACC_W-1:0] w_acc_sum;

    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out_p;
    logic                    r_out_ovf;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_busy;
    logic                    r_grp_ovf;

    // A held result freezes every stage, including the input.
    assign w_en         = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready = w_en;

    example_mul_mac_pipe_mult #(
        .A_W   (A_W),
        .B_W   (B_W),
        .DEPTH (NUM_STAGE - 1)
    ) u_mult (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_en    (w_en),
        .i_valid (bus.in_valid),
        .i_mode  (bus.in_mode),
        .i_last  (bus.in_last),
        .i_a     (bus.in_a),
        .i_b     (bus.in_b),
        .o_valid (w_s_valid),
        .o_mode  (w_s_mode),
        .o_last  (w_s_last),
        .o_prod  (w_s_prod)
    );

    assign w_prod_ext = ACC_W'(w_s_prod);

    // One guard bit detects overflow; the guard's sign picks the clamp side.
    assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
    assign w_add_sat  = w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1];
    assign w_acc_sum  = !w_add_sat         ? w_sum_wide[ACC_W-1:0] :
                        w_sum_wide[ACC_W]  ? c_acc_min : c_acc_max;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_ovf   <= 1'b0;
            r_acc       <= '0;
            r_busy      <= 1'b0;
            r_grp_ovf   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= 1'b0;
            if (w_s_valid) begin
                if (w_s_mode == MODE_MUL) begin
                    r_out_valid <= 1'b1;
                    r_out_p     <= w_prod_ext;
                    r_out_ovf   <= 1'b0;
                end else if (w_s_last) begin
                    r_out_valid <= 1'b1;
                    r_out_p     <= w_acc_sum;
                    r_out_ovf   <= r_grp_ovf | w_add_sat;
                    r_acc       <= '0;
                    r_busy      <= 1'b0;
                    r_grp_ovf   <= 1'b0;
                end else begin
                    r_acc       <= w_acc_sum;
                    r_busy      <= 1'b1;
                    r_grp_ovf   <= r_grp_ovf | w_add_sat;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_p     = r_out_p;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_example_mul_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_example_mul_mac_pipe
// Description : Directed vector bench for example_mul_mac_pipe (32-bit and
//               24-bit accumulator instances driven in lockstep).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_example_mul_mac_pipe;
    import example_mac_pkg::*;

    localparam int A_W       = 14;
    localparam int B_W       = 8;
    localparam int ACC_W     = 32;
    localparam int ACC_W_SAT = 24;
    localparam int NUM_STAGE = 3;

    typedef struct {
        int   a;
        int   b;
        logic mode;
        logic last;
        logic exp_out;
        int   exp_p;
        logic exp_ovf;
        int   exp_p24;
        logic exp_ovf24;
        logic exp_busy;
    } row_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    row_t rows[$];
    int   mon_q[$];

    always #5 clk = ~clk;

    example_mul_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W))     bus ();
    example_mul_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W_SAT)) bus24 ();

    assign bus24.in_valid  = bus.in_valid;
    assign bus24.in_a      = bus.in_a;
    assign bus24.in_b      = bus.in_b;
    assign bus24.in_mode   = bus.in_mode;
    assign bus24.in_last   = bus.in_last;
    assign bus24.out_ready = bus.out_ready;

    example_mul_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .NUM_STAGE(NUM_STAGE)) u_dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus.slave)
    );

    example_mul_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W_SAT), .NUM_STAGE(NUM_STAGE)) u_dut24 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus24.slave)
    );

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) mon_q.push_back(int'(bus.out_p));
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int a, input int b, input logic mode, input logic last, input logic eo,
                       input int p, input logic ovf, input int p24, input logic ovf24, input logic busy);
        row_t r;
        r = '{a, b, mode, last, eo, p, ovf, p24, ovf24, busy};
        rows.push_back(r);
    endtask

    task automatic drive(input int a, input int b, input logic mode, input logic last);
        bus.in_a     = A_W'(a);
        bus.in_b     = B_W'(b);
        bus.in_mode  = mode;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
    endtask

    // One beat, then idle until its result (if any) is visible NUM_STAGE cycles later.
    task automatic run_row(input string tag, input row_t r);
        drive(r.a, r.b, r.mode, r.last);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk({tag, "_early"}, bus.out_valid, 0);
        tick();
        chk({tag, "_valid"}, bus.out_valid, r.exp_out);
        if (r.exp_out) begin
            chk({tag, "_p"},     bus.out_p,     r.exp_p);
            chk({tag, "_ovf"},   bus.out_ovf,   r.exp_ovf);
            chk({tag, "_p24"},   bus24.out_p,   r.exp_p24);
            chk({tag, "_ovf24"}, bus24.out_ovf, r.exp_ovf24);
        end
        chk({tag, "_busy"}, bus.busy, r.exp_busy);
        tick();
    endtask

    initial begin
        int   idx;
        logic seen_stall;
        logic held_valid;
        int   held_p;
        logic acc_now;
        row_t r;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_mode   = MODE_MUL;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_p",     bus.out_p,     0);
        chk("rst_out_ovf",   bus.out_ovf,   0);
        chk("rst_busy",      bus.busy,      0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", bus.in_ready, 1);

        //  a      b    mode      last  out  p          ovf  p24        ovf24 busy
        add(-3,    5,   MODE_MUL, 0,    1,   -15,       0,   -15,       0,    0);
        add(-8192, 255, MODE_MUL, 0,    1,   -2088960,  0,   -2088960,  0,    0);
        add(8191,  255, MODE_MUL, 0,    1,   2088705,   0,   2088705,   0,    0);
        add(0,     200, MODE_MUL, 0,    1,   0,         0,   0,         0,    0);
        add(-100,  0,   MODE_MUL, 0,    1,   0,         0,   0,         0,    0);
        add(5,     255, MODE_MUL, 1,    1,   1275,      0,   1275,      0,    0);
        add(2,     3,   MODE_ACC, 0,    0,   0,         0,   0,         0,    1);
        add(4,     5,   MODE_ACC, 0,    0,   0,         0,   0,         0,    1);
        add(7,     9,   MODE_MUL, 0,    1,   63,        0,   63,        0,    1);
        add(-1,    10,  MODE_ACC, 1,    1,   16,        0,   16,        0,    0);
        add(1,     1,   MODE_ACC, 1,    1,   1,         0,   1,         0,    0);
        for (int i = 0; i < 4; i++) add(8191, 255, MODE_ACC, 0, 0, 0, 0, 0, 0, 1);
        add(8191,  255, MODE_ACC, 1,    1,   10443525,  0,   8388607,   1,    0);
        for (int i = 0; i < 5; i++) add(-8192, 255, MODE_ACC, 0, 0, 0, 0, 0, 0, 1);
        add(8191,  255, MODE_ACC, 1,    1,   -8356095,  0,   -6299903,  1,    0);
        add(1,     1,   MODE_ACC, 1,    1,   1,         0,   1,         0,    0);

        foreach (rows[i]) run_row($sformatf("row%0d", i), rows[i]);

        // Back-to-back beats with out_ready held high: one accepted every cycle.
        mon_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive(i * 1500 - 4000, 200 + i * 10, MODE_MUL, 1'b0);
            chk($sformatf("tp_in_ready%0d", i), bus.in_ready, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("tp_count", mon_q.size(), 6);
        for (int i = 0; i < 6 && i < mon_q.size(); i++)
            chk($sformatf("tp_p%0d", i), mon_q[i], (i * 1500 - 4000) * (200 + i * 10));

        // Continuous input while out_ready drops for four cycles.
        mon_q.delete();
        idx        = 0;
        seen_stall = 1'b0;
        held_valid = 1'b0;
        held_p     = 0;
        for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            drive(idx * 37 - 100, idx * 13 + 1, MODE_MUL, 1'b0);
            #1;
            acc_now = bus.in_valid && bus.in_ready;
            if (!bus.in_ready) seen_stall = 1'b1;
            if (bus.out_valid && !bus.out_ready) begin
                if (held_valid) chk($sformatf("bp_hold%0d", cyc), bus.out_p, held_p);
                held_p     = int'(bus.out_p);
                held_valid = 1'b1;
            end else begin
                held_valid = 1'b0;
            end
            tick();
            if (acc_now) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_accepted", idx, 10);
        chk("bp_stalled", seen_stall, 1);
        repeat (8) tick();
        chk("bp_count", mon_q.size(), 10);
        for (int i = 0; i < 10 && i < mon_q.size(); i++)
            chk($sformatf("bp_p%0d", i), mon_q[i], (i * 37 - 100) * (i * 13 + 1));

        // Reset with a partial sum and a multiply beat still in flight.
        mon_q.delete();
        drive(3, 4, MODE_ACC, 1'b0);
        tick();
        drive(5, 6, MODE_ACC, 1'b0);
        tick();
        drive(2, 2, MODE_MUL, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk("mr_busy_before", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy_in_rst",  bus.busy,      0);
        chk("mr_valid_in_rst", bus.out_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("mr_no_output", mon_q.size(), 0);
        chk("mr_in_ready", bus.in_ready, 1);
        r = '{1, 1, MODE_ACC, 1'b1, 1'b1, 1, 1'b0, 1, 1'b0, 1'b0};
        run_row("mr_after", r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
